dma_copy_engine: RTL and testbench
==================================

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data bus width in bits; allowed values are 32 and 64; one word = DATA_W/8 bytes.
REQ-002 SHALL have parameter MAX_BURST, default 16: maximum beats per burst; range 1..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32: buffer depth in words; power of 2; at least MAX_BURST.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a copy.
REQ-007 src_addr  in  32  source byte address, word aligned.
REQ-008 dst_addr  in  32  destination byte address, word aligned.
REQ-009 word_cnt  in  16  number of words to copy.
REQ-010 busy  out  1  high while a copy is in progress.
REQ-011 done  out  1  one-cycle pulse at copy completion.
REQ-012 err  out  1  sticky flag: an RRESP or BRESP was nonzero.
REQ-013 ARADDR_M  out  32 / ARLEN_M  out  4 / ARVALID_M  out  1 / ARREADY_M  in  1: read-address channel.
REQ-014 RDATA_M  in  DATA_W / RRESP_M  in  2 / RLAST_M  in  1 / RVALID_M  in  1 / RREADY_M  out  1: read-data channel.
REQ-015 AWADDR_M  out  32 / AWLEN_M  out  4 / AWVALID_M  out  1 / AWREADY_M  in  1: write-address channel.
REQ-016 WDATA_M  out  DATA_W / WLAST_M  out  1 / WVALID_M  out  1 / WREADY_M  in  1: write-data channel.
REQ-017 BRESP_M  in  2 / BVALID_M  in  1 / BREADY_M  out  1: write-response channel.

Function
REQ-018 Bursts SHALL be INCR with full strobes and size equal to DATA_W; ID, SIZE and BURST are fixed externally.
REQ-019 start while idle SHALL latch src, dst and word_cnt, assert busy next cycle, and clear err; start while busy SHALL be ignored.
REQ-020 start with word_cnt=0 SHALL produce a done pulse on the next cycle without asserting busy and without any bus traffic.
REQ-021 Read FSM SHALL use states R_IDLE, R_ADDR and R_DATA; write FSM SHALL use states W_IDLE, W_ADDR, W_DATA and W_RESP; the two run concurrently.
REQ-022 Burst length SHALL be min(MAX_BURST, words remaining, words to the next 4 KB boundary); xLEN = length-1.
REQ-023 Read FSM SHALL enter R_ADDR only when free FIFO space is at least the next burst length; free space counts words reserved by outstanding reads.
REQ-024 RREADY_M SHALL be high in R_DATA; each beat SHALL be pushed into the FIFO; RLAST returns the FSM to R_ADDR, or to R_IDLE when all words have been requested.
REQ-025 Write FSM SHALL enter W_ADDR only when FIFO occupancy is at least the next write burst length.
REQ-026 In W_DATA: WDATA_M = FIFO head and WVALID_M = 1; the head pops on WREADY_M; WLAST_M SHALL be high on the final beat of the burst.
REQ-027 Write FSM SHALL hold BREADY_M high in W_RESP and on the B handshake go to W_ADDR, or to W_IDLE when all words have been written.
REQ-028 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; the FIFO SHALL never overflow or underflow.
REQ-029 xVALID and all payload signals SHALL hold steady until their handshake completes.
REQ-030 A nonzero RRESP on any beat, or a nonzero BRESP, SHALL set err; the copy continues to completion.
REQ-031 The final B handshake SHALL pulse done for one cycle and deassert busy in that same cycle.

Reset
REQ-032 Assertion of rstn low SHALL, asynchronously and even mid-transfer, force both FSMs idle, empty the FIFO, and drive every output to 0, including busy, done, err, all VALID/READY and all address/data.

Verification
REQ-033 src=0x1000, dst=0x2000, word_cnt=40, ready always high -> AR and AW lengths 15,15,7; destination matches source; one done pulse; err=0.
REQ-034 src=0x0FF8, word_cnt=8 -> read bursts of 2 then 6 words (4 KB split at 0x1000); writes split at their own 4 KB boundaries.
REQ-035 WREADY_M held low for 100 cycles with FIFO_DEPTH=32 -> at most 32 words accepted; RREADY_M/AR stall; no data loss after release.
REQ-036 RRESP=2 on beat 3 -> err=1 at completion; all words still written; next start clears err.
REQ-037 rstn pulsed low during a W_DATA burst -> outputs 0 immediately; a new start afterwards completes correctly.
REQ-038 word_cnt=0 -> done pulse next cycle, busy stays 0, no ARVALID/AWVALID; start while busy -> ignored.

Source files
------------

// File: rtl/dma_copy_engine_if.sv
// Memory-side bus of the DMA copy engine: AXI-style read-address, read-data,
// write-address, write-data and write-response channels.
//   master modport : the copy engine (drives addresses, write data, R/B ready)
//   slave  modport : the memory / interconnect model
// Burst type, size and ID are tied off outside this bundle, so only address,
// length, data, last, response and the valid/ready pairs are carried.
interface dma_copy_engine_if #(
  parameter int DATA_W = 32
);
  // read address channel
  logic [31:0]       ARADDR_M;
  logic [3:0]        ARLEN_M;
  logic              ARVALID_M;
  logic              ARREADY_M;
  // read data channel
  logic [DATA_W-1:0] RDATA_M;
  logic [1:0]        RRESP_M;
  logic              RLAST_M;
  logic              RVALID_M;
  logic              RREADY_M;
  // write address channel
  logic [31:0]       AWADDR_M;
  logic [3:0]        AWLEN_M;
  logic              AWVALID_M;
  logic              AWREADY_M;
  // write data channel
  logic [DATA_W-1:0] WDATA_M;
  logic              WLAST_M;
  logic              WVALID_M;
  logic              WREADY_M;
  // write response channel
  logic [1:0]        BRESP_M;
  logic              BVALID_M;
  logic              BREADY_M;

  modport master (
    output ARADDR_M, ARLEN_M, ARVALID_M,
    input  ARREADY_M,
    input  RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M,
    output AWADDR_M, AWLEN_M, AWVALID_M,
    input  AWREADY_M,
    output WDATA_M, WLAST_M, WVALID_M,
    input  WREADY_M,
    input  BRESP_M, BVALID_M,
    output BREADY_M
  );

  modport slave (
    input  ARADDR_M, ARLEN_M, ARVALID_M,
    output ARREADY_M,
    output RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M,
    input  AWADDR_M, AWLEN_M, AWVALID_M,
    output AWREADY_M,
    input  WDATA_M, WLAST_M, WVALID_M,
    output WREADY_M,
    output BRESP_M, BVALID_M,
    input  BREADY_M
  );
endinterface

// File: rtl/dma_copy_engine.sv
// DMA copy engine: copies word_cnt words from src_addr to dst_addr using INCR
// bursts on the memory bus. A read FSM fills an internal FIFO and a write FSM
// drains it; the two run concurrently.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   start              : one-cycle request; ignored while busy
//   src_addr, dst_addr : word-aligned byte addresses
//   word_cnt           : number of words to copy (0 gives an immediate done)
//   busy, done, err    : copy in progress, completion pulse, sticky bus error
//   axi                : memory bus (master side)
module dma_copy_engine #(
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [15:0]          word_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  dma_copy_engine_if.master    axi
);

  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  r_state_e          r_state_q, r_state_d;
  w_state_e          w_state_q, w_state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rd_addr_q, rd_addr_d;
  logic [15:0]       rd_rem_q, rd_rem_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [15:0]       wr_rem_q, wr_rem_d;
  logic [4:0]        rd_outst_q, rd_outst_d;
  logic [3:0]        w_beat_q, w_beat_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [4:0]        rd_len;
  logic [4:0]        wr_len;
  logic [16:0]       fifo_free;
  logic              rd_space_ok;
  logic              wr_data_ok;
  logic              push;
  logic              pop;

  // Burst length: the smallest of MAX_BURST, the words left and the words up
  // to the next 4 KB boundary (a burst must never cross one).
  function automatic logic [4:0] burst_len(input logic [31:0] addr,
                                           input logic [15:0] rem);
    logic [12:0] to_bnd;
    logic [15:0] len;
    to_bnd = (13'h1000 - {1'b0, addr[11:0]}) >> SHIFT;
    len    = 16'(MAX_BURST);
    if ({3'b000, to_bnd} < len) len = {3'b000, to_bnd};
    if (rem < len)              len = rem;
    return len[4:0];
  endfunction

  assign rd_len = burst_len(rd_addr_q, rd_rem_q);
  assign wr_len = burst_len(wr_addr_q, wr_rem_q);

  // Free space also subtracts beats of the read burst still in flight, so a
  // read is only issued when every one of its beats is guaranteed a slot.
  assign fifo_free   = 17'(FIFO_DEPTH) - 17'(fifo_cnt_q) - 17'(rd_outst_q);
  assign rd_space_ok = fifo_free >= 17'(rd_len);
  assign wr_data_ok  = 17'(fifo_cnt_q) >= 17'(wr_len);

  assign push = (r_state_q == R_DATA) && axi.RVALID_M;
  assign pop  = (w_state_q == W_DATA) && axi.WREADY_M;

  always_comb begin
    r_state_d  = r_state_q;
    w_state_d  = w_state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rd_addr_d  = rd_addr_q;
    rd_rem_d   = rd_rem_q;
    wr_addr_d  = wr_addr_q;
    wr_rem_d   = wr_rem_q;
    rd_outst_d = rd_outst_q;
    w_beat_d   = w_beat_q;

    if (start && !busy_q) begin
      rd_addr_d = src_addr;
      wr_addr_d = dst_addr;
      rd_rem_d  = word_cnt;
      wr_rem_d  = word_cnt;
      err_d     = 1'b0;
      if (word_cnt == 16'd0) done_d = 1'b1;
      else                   busy_d = 1'b1;
    end

    case (r_state_q)
      R_IDLE: begin
        if (busy_q && (rd_rem_q != 16'd0) && rd_space_ok) begin
          r_state_d  = R_ADDR;
          rd_outst_d = rd_len;
        end
      end
      R_ADDR: begin
        // Address/length stay frozen until ARREADY; they advance on the handshake.
        if (axi.ARREADY_M) begin
          r_state_d = R_DATA;
          rd_addr_d = rd_addr_q + (32'(rd_len) << SHIFT);
          rd_rem_d  = rd_rem_q - 16'(rd_len);
        end
      end
      R_DATA: begin
        if (axi.RVALID_M) begin
          rd_outst_d = rd_outst_q - 5'd1;
          if (axi.RRESP_M != 2'b00) err_d = 1'b1;
          if (axi.RLAST_M) begin
            rd_outst_d = 5'd0;
            if ((rd_rem_q != 16'd0) && rd_space_ok) begin
              r_state_d  = R_ADDR;
              rd_outst_d = rd_len;
            end else begin
              // Either everything is requested or we wait in idle for space.
              r_state_d = R_IDLE;
            end
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    case (w_state_q)
      W_IDLE: begin
        if (busy_q && (wr_rem_q != 16'd0) && wr_data_ok) w_state_d = W_ADDR;
      end
      W_ADDR: begin
        if (axi.AWREADY_M) begin
          w_state_d = W_DATA;
          w_beat_d  = 4'(wr_len - 5'd1);
          wr_addr_d = wr_addr_q + (32'(wr_len) << SHIFT);
          wr_rem_d  = wr_rem_q - 16'(wr_len);
        end
      end
      W_DATA: begin
        // w_beat_q counts beats left after the current one; zero marks WLAST.
        if (axi.WREADY_M) begin
          if (w_beat_q == 4'd0) w_state_d = W_RESP;
          else                  w_beat_d  = w_beat_q - 4'd1;
        end
      end
      W_RESP: begin
        if (axi.BVALID_M) begin
          if (axi.BRESP_M != 2'b00) err_d = 1'b1;
          if (wr_rem_q == 16'd0) begin
            w_state_d = W_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else if (wr_data_ok) begin
            w_state_d = W_ADDR;
          end else begin
            w_state_d = W_IDLE;
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q  <= R_IDLE;
      w_state_q  <= W_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_addr_q  <= '0;
      rd_rem_q   <= '0;
      wr_addr_q  <= '0;
      wr_rem_q   <= '0;
      rd_outst_q <= '0;
      w_beat_q   <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_addr_q  <= rd_addr_d;
      rd_rem_q   <= rd_rem_d;
      wr_addr_q  <= wr_addr_d;
      wr_rem_q   <= wr_rem_d;
      rd_outst_q <= rd_outst_d;
      w_beat_q   <= w_beat_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage only; emptiness is tracked by the pointers/count above.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= axi.RDATA_M;
  end

  // Outputs are decoded from state so reset zeroes them immediately; payloads
  // are forced to zero whenever their valid is low.
  assign axi.ARVALID_M = (r_state_q == R_ADDR);
  assign axi.ARADDR_M  = axi.ARVALID_M ? rd_addr_q : 32'd0;
  assign axi.ARLEN_M   = axi.ARVALID_M ? 4'(rd_len - 5'd1) : 4'd0;
  assign axi.RREADY_M  = (r_state_q == R_DATA);

  assign axi.AWVALID_M = (w_state_q == W_ADDR);
  assign axi.AWADDR_M  = axi.AWVALID_M ? wr_addr_q : 32'd0;
  assign axi.AWLEN_M   = axi.AWVALID_M ? 4'(wr_len - 5'd1) : 4'd0;
  assign axi.WVALID_M  = (w_state_q == W_DATA);
  assign axi.WDATA_M   = axi.WVALID_M ? fifo_mem[rd_ptr_q] : '0;
  assign axi.WLAST_M   = axi.WVALID_M && (w_beat_q == 4'd0);
  assign axi.BREADY_M  = (w_state_q == W_RESP);

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'd0;
  logic [31:0] dst_addr = 32'd0;
  logic [15:0] word_cnt = 16'd0;
  logic        busy, done, err;

  dma_copy_engine_if #(.DATA_W(32)) bus ();

  dma_copy_engine #(.DATA_W(32), .MAX_BURST(16), .FIFO_DEPTH(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .word_cnt (word_cnt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .axi      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;   // data word, or burst length field for AR/AW entries
  } xfer_t;

  // scoreboards: expectations pushed with the stimulus, popped on DUT output
  xfer_t exp_ar[$];
  xfer_t exp_aw[$];
  xfer_t exp_w[$];
  // slave-side outstanding bursts
  xfer_t rq[$];
  xfer_t wq[$];

  logic [31:0] mem [0:16383];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;
  bit wready_en = 1'b1;
  int err_beat = -1;
  int r_total = 0;
  int done_cnt = 0;
  int arv_cyc = 0;
  int awv_cyc = 0;

  bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [31:0] r_addr, w_addr;
  int r_len, r_beat, w_len, w_beat, bpend;
  bit w_act;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_r();
    logic [31:0] a;
    a = r_addr + 32'(4 * r_beat);
    bus.RDATA_M = mem[a[15:2]];
    bus.RRESP_M = (r_total == err_beat) ? 2'd2 : 2'd0;
    bus.RLAST_M = (r_beat == r_len);
  endtask

  // memory slave model plus output monitors
  initial begin
    xfer_t e;
    xfer_t bst;
    logic [31:0] a;
    bus.ARREADY_M = 1'b1;
    bus.AWREADY_M = 1'b1;
    bus.RVALID_M  = 1'b0;
    bus.RDATA_M   = '0;
    bus.RRESP_M   = 2'd0;
    bus.RLAST_M   = 1'b0;
    bus.WREADY_M  = 1'b0;
    bus.BVALID_M  = 1'b0;
    bus.BRESP_M   = 2'd0;
    r_len = 0; r_beat = 0; w_len = 0; w_beat = 0; bpend = 0; w_act = 1'b0;
    r_addr = '0; w_addr = '0;
    forever begin
      @(negedge clk);
      ar_hs = bus.ARVALID_M && bus.ARREADY_M;
      r_hs  = bus.RVALID_M  && bus.RREADY_M;
      aw_hs = bus.AWVALID_M && bus.AWREADY_M;
      w_hs  = bus.WVALID_M  && bus.WREADY_M;
      b_hs  = bus.BVALID_M  && bus.BREADY_M;
      if (!rstn) begin
        rq.delete(); wq.delete();
        w_act = 1'b0; bpend = 0;
        ar_hs = 1'b0; r_hs = 1'b0; aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0;
      end else begin
        if (bus.ARVALID_M) arv_cyc++;
        if (bus.AWVALID_M) awv_cyc++;
        if (done) done_cnt++;
        if (r_hs) r_total++;
        if (ar_hs) begin
          rq.push_back({bus.ARADDR_M, 28'd0, bus.ARLEN_M});
          if (chk_en) begin
            chk("ar_expected", 64'(exp_ar.size() > 0), 64'(1));
            if (exp_ar.size() > 0) begin
              e = exp_ar.pop_front();
              chk("ar_addr_len", {bus.ARADDR_M, 28'd0, bus.ARLEN_M}, e);
            end
          end
        end
        if (aw_hs) begin
          wq.push_back({bus.AWADDR_M, 28'd0, bus.AWLEN_M});
          if (chk_en) begin
            chk("aw_expected", 64'(exp_aw.size() > 0), 64'(1));
            if (exp_aw.size() > 0) begin
              e = exp_aw.pop_front();
              chk("aw_addr_len", {bus.AWADDR_M, 28'd0, bus.AWLEN_M}, e);
            end
          end
        end
        if (w_hs) begin
          if (!w_act && wq.size() > 0) begin
            bst = wq.pop_front();
            w_addr = bst.addr; w_len = int'(bst.data); w_beat = 0; w_act = 1'b1;
          end
          chk("w_after_aw", 64'(w_act), 64'(1));
          if (w_act) begin
            a = w_addr + 32'(4 * w_beat);
            mem[a[15:2]] = bus.WDATA_M;
            if (chk_en) begin
              chk("wlast", 64'(bus.WLAST_M), 64'(w_beat == w_len));
              chk("w_expected", 64'(exp_w.size() > 0), 64'(1));
              if (exp_w.size() > 0) begin
                e = exp_w.pop_front();
                chk("w_addr_data", {a, bus.WDATA_M}, e);
              end
            end
            w_beat++;
            if (w_beat > w_len) begin
              w_act = 1'b0;
              bpend++;
            end
          end
        end
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        bus.RVALID_M = 1'b0;
        bus.RLAST_M  = 1'b0;
        bus.BVALID_M = 1'b0;
        bus.WREADY_M = wready_en;
      end else begin
        if (r_hs) begin
          if (r_beat == r_len) begin
            bus.RVALID_M = 1'b0;
            bus.RLAST_M  = 1'b0;
          end else begin
            r_beat++;
            drive_r();
          end
        end
        if (!bus.RVALID_M && rq.size() > 0) begin
          bst = rq.pop_front();
          r_addr = bst.addr; r_len = int'(bst.data); r_beat = 0;
          bus.RVALID_M = 1'b1;
          drive_r();
        end
        if (b_hs) bus.BVALID_M = 1'b0;
        if (!bus.BVALID_M && bpend > 0) begin
          bus.BVALID_M = 1'b1;
          bus.BRESP_M  = 2'd0;
          bpend--;
        end
        bus.WREADY_M = wready_en;
      end
    end
  end

  task automatic push_exp(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa;
    for (int k = 0; k < n; k++) begin
      sa = s + 32'(4 * k);
      exp_w.push_back({d + 32'(4 * k), mem[sa[15:2]]});
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input int len);
    exp_ar.push_back({a, 32'(len)});
  endtask

  task automatic push_aw(input logic [31:0] a, input int len);
    exp_aw.push_back({a, 32'(len)});
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    r_total  = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; word_cnt = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(n != 16'd0));
    chk("err_cleared_on_start", 64'(err), 64'(0));
  endtask

  task automatic wait_done(input string tag, input int max_cyc, input bit exp_err);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    if (seen) chk({tag, "_busy_low_at_done"}, 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    chk({tag, "_one_done_pulse"}, 64'(done_cnt), 64'(1));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_w_left"}, 64'(exp_w.size()), 64'(0));
    chk({tag, "_ar_left"}, 64'(exp_ar.size()), 64'(0));
    chk({tag, "_aw_left"}, 64'(exp_aw.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 16384; i++) mem[i] = {~16'(i), 16'(i)} ^ 32'h5A3C_0000;

    // reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_valid_ready", 64'({bus.ARVALID_M, bus.AWVALID_M, bus.WVALID_M,
                                bus.RREADY_M, bus.BREADY_M, bus.WLAST_M}), 64'(0));
    chk("rst_addr", {bus.ARADDR_M, bus.AWADDR_M}, 64'(0));
    @(negedge clk);
    rstn = 1'b1;

    // 40 words, 64-byte aligned: bursts of 16,16,8; a start while busy is ignored
    push_exp(32'h1000, 32'h2000, 40);
    push_ar(32'h1000, 15); push_ar(32'h1040, 15); push_ar(32'h1080, 7);
    push_aw(32'h2000, 15); push_aw(32'h2040, 15); push_aw(32'h2080, 7);
    start_copy(32'h1000, 32'h2000, 16'd40);
    repeat (4) @(posedge clk);
    #1;
    src_addr = 32'h7000; dst_addr = 32'h7100; word_cnt = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t1", 2000, 1'b0);

    // read crosses 4 KB at 0x1000 (2 + 6), write crosses at 0x6000 (4 + 4)
    push_exp(32'h0FF8, 32'h5FF0, 8);
    push_ar(32'h0FF8, 1); push_ar(32'h1000, 5);
    push_aw(32'h5FF0, 3); push_aw(32'h6000, 3);
    start_copy(32'h0FF8, 32'h5FF0, 16'd8);
    wait_done("t2", 1000, 1'b0);

    // write stall: FIFO fills with 32 words, reads stop, then drain completes
    wready_en = 1'b0;
    push_exp(32'h0000, 32'h8000, 64);
    for (int k = 0; k < 4; k++) begin
      push_ar(32'(64 * k), 15);
      push_aw(32'h8000 + 32'(64 * k), 15);
    end
    start_copy(32'h0000, 32'h8000, 16'd64);
    repeat (100) @(negedge clk);
    chk("stall_words_accepted", 64'(r_total), 64'(32));
    chk("stall_rready_low", 64'(bus.RREADY_M), 64'(0));
    chk("stall_arvalid_low", 64'(bus.ARVALID_M), 64'(0));
    chk("stall_wvalid_held", 64'(bus.WVALID_M), 64'(1));
    chk("stall_busy", 64'(busy), 64'(1));
    wready_en = 1'b1;
    wait_done("t3", 2000, 1'b0);

    // read error on beat index 3: copy still completes, err sticky
    err_beat = 3;
    push_exp(32'h0100, 32'h0200, 10);
    push_ar(32'h0100, 9);
    push_aw(32'h0200, 9);
    start_copy(32'h0100, 32'h0200, 16'd10);
    wait_done("t4", 1000, 1'b1);
    err_beat = -1;

    // reset in the middle of a write burst, then a fresh copy
    chk_en = 1'b0;
    start_copy(32'h0400, 32'h0900, 16'd32);
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.WVALID_M) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_wdata_phase_reached", 64'(seen), 64'(1));
    #1;
    rstn = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_wvalid", 64'(bus.WVALID_M), 64'(0));
    chk("t5_rst_wdata", 64'(bus.WDATA_M), 64'(0));
    chk("t5_rst_others", 64'({done, err, bus.ARVALID_M, bus.AWVALID_M, bus.RREADY_M,
                              bus.BREADY_M, bus.WLAST_M, bus.ARLEN_M, bus.AWLEN_M}), 64'(0));
    chk("t5_rst_addr", {bus.ARADDR_M, bus.AWADDR_M}, 64'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    chk_en = 1'b1;
    push_exp(32'h0400, 32'h0A00, 20);
    push_ar(32'h0400, 15); push_ar(32'h0440, 3);
    push_aw(32'h0A00, 15); push_aw(32'h0A40, 3);
    start_copy(32'h0400, 32'h0A00, 16'd20);
    wait_done("t5", 1000, 1'b0);

    // zero-length copy: done next cycle, never busy, no bus traffic
    arv_cyc = 0;
    awv_cyc = 0;
    start_copy(32'h0000, 32'h0000, 16'd0);
    chk("t6_done_next_cycle", 64'(done), 64'(1));
    @(posedge clk); #1;
    chk("t6_done_one_cycle", 64'(done), 64'(0));
    chk("t6_busy_low", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    chk("t6_no_arvalid", 64'(arv_cyc), 64'(0));
    chk("t6_no_awvalid", 64'(awv_cyc), 64'(0));
    chk("t6_one_done_pulse", 64'(done_cnt), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
